// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss handler for a 2-way, 64-set cache with 16-byte blocks (8 x 16-bit
// words). On a miss it streams WORDS back-to-back read requests to the
// pipelined main memory. Each returned word goes into the cache data array.
// When the last word has been written, the block raises a one-cycle tag-array
// write so the cache can install the tag and update LRU/valid bits.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst                 synchronous active-low reset
//   miss_detected       cache reports a miss on the current access
//   miss_address[15:0]  byte address of the missing access
//   memory_data[15:0]   read data returned by main memory
//   memory_data_valid   memory_data is valid this cycle
//   fsm_busy            fill in progress, pipeline must stall
//   mem_read            read request to main memory this cycle
//   memory_address      address of the current memory read request
//   write_data_array    write fill_data into the data array this cycle
//   cache_write_address cache address of the word being written (base in TAG)
//   fill_data           word to write, a combinational copy of memory_data
//   write_tag_array     one-cycle pulse to write tag and meta data
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int unsigned WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [15:0] cache_write_address,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  // Counters carry one extra bit so that issue_cnt can reach WORDS.
  localparam int unsigned CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C  = CW'(WORDS - 1);
  // Clears the byte offset within the block (2*WORDS bytes per block).
  localparam logic [15:0] BLK_MASK = ~16'((2 * WORDS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAG
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] recv_cnt_q, recv_cnt_d;
  logic [15:0]   base_q, base_d;

  logic issue_en;
  logic write_en;

  // Byte offset of word idx within the block.
  function automatic logic [15:0] word_off(input logic [CW-1:0] idx);
    return 16'(idx) << 1;
  endfunction

  // Requests go out back-to-back until all words have been issued. A return
  // counts only while a request is still outstanding, so stray valids are
  // dropped.
  always_comb begin
    issue_en = (state_q == FILL) && (issue_cnt_q < WORDS_C);
    write_en = (state_q == FILL) && memory_data_valid &&
               (recv_cnt_q < issue_cnt_q);
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = miss_address & BLK_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (issue_en) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (write_en) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_C) begin
            state_d = TAG;
          end
        end
      end
      TAG: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  // Outputs are decoded from registered state. The only exceptions are
  // write_data_array and fill_data, which follow memory_data_valid and
  // memory_data in the same cycle.
  always_comb begin
    fsm_busy            = 1'b0;
    mem_read            = 1'b0;
    memory_address      = '0;
    write_data_array    = 1'b0;
    cache_write_address = '0;
    write_tag_array     = 1'b0;
    fill_data           = memory_data;
    case (state_q)
      FILL: begin
        fsm_busy            = 1'b1;
        mem_read            = issue_en;
        // After the last request the address holds its final value.
        memory_address      = issue_en ? (base_q + word_off(issue_cnt_q))
                                       : (base_q + word_off(LAST_C));
        write_data_array    = write_en;
        cache_write_address = base_q + word_off(recv_cnt_q);
      end
      TAG: begin
        fsm_busy            = 1'b1;
        memory_address      = base_q + word_off(LAST_C);
        cache_write_address = base_q;
        write_tag_array     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] cache_write_address;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .miss_detected       (miss_detected),
    .miss_address        (miss_address),
    .memory_data         (memory_data),
    .memory_data_valid   (memory_data_valid),
    .fsm_busy            (fsm_busy),
    .mem_read            (mem_read),
    .memory_address      (memory_address),
    .write_data_array    (write_data_array),
    .cache_write_address (cache_write_address),
    .fill_data           (fill_data),
    .write_tag_array     (write_tag_array)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then settle mid-cycle.
  task automatic drive(input logic r, input logic m, input logic [15:0] a,
                       input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst               = r;
    miss_detected     = m;
    miss_address      = a;
    memory_data_valid = v;
    memory_data       = d;
    #3;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 16'(fsm_busy), 16'h0);
    check({tag, ".rd"},   16'(mem_read), 16'h0);
    check({tag, ".wda"},  16'(write_data_array), 16'h0);
    check({tag, ".tag"},  16'(write_tag_array), 16'h0);
    check({tag, ".maddr"}, memory_address, 16'h0000);
    check({tag, ".caddr"}, cache_write_address, 16'h0000);
    check({tag, ".fdata"}, fill_data, memory_data);
  endtask

  function automatic logic [15:0] data_for(input logic [15:0] addr);
    return addr ^ 16'h5AC3;
  endfunction

  // One complete fill with memory latency 4. pat bit i means a word returns
  // in cycle 5+i (cycle 0 is the miss cycle).
  task automatic run_fill(input logic [15:0] miss_a, input logic [15:0] exp_base,
                          input logic [31:0] pat, input bit stray,
                          input bit busy_miss);
    int n;
    int rel;
    logic v;
    logic exp_wr;
    logic m;
    logic [15:0] d;
    drive(1'b1, 1'b1, miss_a, stray, 16'hDEAD);
    check("c0.busy", 16'(fsm_busy), 16'h0);
    check("c0.wda", 16'(write_data_array), 16'h0);
    n = 0;
    rel = 0;
    while (n < 8 && rel < 40) begin
      rel++;
      exp_wr = (rel >= 5) ? pat[rel-5] : 1'b0;
      v      = exp_wr | (stray && rel == 1);
      d      = exp_wr ? data_for(exp_base + 16'(2 * n)) : 16'hBEEF;
      m      = busy_miss && (rel == 3);
      drive(1'b1, m, 16'hABC0, v, d);
      check("fill.busy", 16'(fsm_busy), 16'h1);
      check("fill.rd", 16'(mem_read), (rel <= 8) ? 16'h1 : 16'h0);
      check("fill.maddr", memory_address,
            (rel <= 8) ? exp_base + 16'(2 * (rel - 1)) : exp_base + 16'h000E);
      check("fill.wda", 16'(write_data_array), 16'(exp_wr));
      check("fill.tag", 16'(write_tag_array), 16'h0);
      if (exp_wr) begin
        check("fill.caddr", cache_write_address, exp_base + 16'(2 * n));
        check("fill.fdata", fill_data, d);
        n++;
      end
    end
    check("fill.words", 16'(n), 16'd8);
    // Tag cycle: valid must be ignored here.
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777);
    check("tag.tag", 16'(write_tag_array), 16'h1);
    check("tag.caddr", cache_write_address, exp_base);
    check("tag.wda", 16'(write_data_array), 16'h0);
    check("tag.rd", 16'(mem_read), 16'h0);
    check("tag.busy", 16'(fsm_busy), 16'h1);
  endtask

  initial begin
    rst               = 1'b0;
    miss_detected     = 1'b1;
    miss_address      = 16'h1234;
    memory_data_valid = 1'b1;
    memory_data       = 16'h1357;

    // Reset held two cycles with miss and valid asserted.
    drive(1'b0, 1'b1, 16'h1234, 1'b1, 16'h1357);
    check_idle("rst1");
    drive(1'b0, 1'b1, 16'h1234, 1'b1, 16'h2468);
    check_idle("rst2");

    // Basic fill at 0x1234, with stray valids in IDLE and in the first FILL
    // cycle and a miss on 0xABC0 mid-fill.
    run_fill(16'h1234, 16'h1230, 32'h0000_00FF, 1'b1, 1'b1);
    // Miss right after TAG at the top of memory, with gapped returns.
    run_fill(16'hFFFE, 16'hFFF0, 32'h0000_15AD, 1'b0, 1'b0);

    // Reset mid-fill after the third returned word.
    drive(1'b1, 1'b1, 16'h456A, 1'b0, 16'h0000);
    check("r.c0.busy", 16'(fsm_busy), 16'h0);
    for (int rel = 1; rel <= 4; rel++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1, data_for(16'h4560 + 16'(2 * k)));
      check("r.wda", 16'(write_data_array), 16'h1);
      check("r.caddr", cache_write_address, 16'h4560 + 16'(2 * k));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("r.pre.busy", 16'(fsm_busy), 16'h1);
    for (int k = 3; k < 8; k++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1, data_for(16'h4560 + 16'(2 * k)));
      check_idle("r.post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss handler for the 2-way, 64-set, 16-byte-block cache, which has 8 x 16-bit words per block. On a miss it fetches the whole block from main memory, one word at a time, and steers each returned word into the cache data array. It then raises a single tag-array write so the cache can install the new tag and update LRU and valid bits. It sits between the cache and the pipelined main-memory model, and stalls the pipeline through fsm_busy.

Parameters:
WORDS, 8, words per block; counters are log2(WORDS) bits plus one overflow bit.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset.
miss_detected  input  1  cache reports a miss on the current access.
miss_address  input  16  byte address of the missing access.
memory_data  input  16  read data returned by main memory.
memory_data_valid  input  1  memory_data is valid this cycle.
fsm_busy  output  1  fill in progress; pipeline must stall.
mem_read  output  1  read request to main memory this cycle.
memory_address  output  16  address of the current memory read request.
write_data_array  output  1  write fill_data into the cache data array this cycle.
cache_write_address  output  16  cache address for the word being written.
fill_data  output  16  word to write; equals memory_data, combinational.
write_tag_array  output  1  one-cycle pulse to write the tag and meta data.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state goes to IDLE; issue_cnt and recv_cnt go to 0; base goes to 0.
  - Outputs are then fsm_busy=0, mem_read=0, write_data_array=0, write_tag_array=0, memory_address=0, cache_write_address=0.
  - Reset mid-fill abandons the fill immediately. Memory data still in flight after reset is ignored, because the block is in IDLE.
- States: IDLE, FILL, TAG.
- IDLE:
  - All outputs are 0 except fill_data=memory_data.
  - memory_data_valid is ignored.
  - If miss_detected=1: latch base={miss_address[15:4],4'b0000}, clear both counters, go to FILL.
- FILL (fsm_busy=1):
  - Issue side: mem_read=1 while issue_cnt<WORDS, with memory_address=base+{issue_cnt,1'b0}. issue_cnt increments every cycle mem_read=1, so there are WORDS back-to-back requests and no backpressure.
  - Once issue_cnt==WORDS: mem_read=0 and memory_address holds its last value.
  - Receive side: write_data_array = memory_data_valid & (recv_cnt<issue_cnt), combinational in the same cycle as valid.
  - On a write: cache_write_address=base+{recv_cnt,1'b0}, then recv_cnt increments.
  - A valid with no outstanding request (recv_cnt==issue_cnt) is ignored and produces no write.
  - Issue and receive proceed in the same cycle independently.
  - When a write occurs with recv_cnt==WORDS-1, go to TAG on the next edge.
- TAG (fsm_busy=1):
  - write_tag_array=1 for exactly one cycle, with cache_write_address=base.
  - mem_read=0, write_data_array=0; memory_data_valid is ignored.
  - Next state is IDLE unconditionally.
- miss_detected is ignored in FILL and TAG. A new fill can start only from IDLE, so the earliest is the cycle after TAG.
- Address arithmetic is 16-bit. The offset field only ever ranges 0x0 to 0xE within the block, so base+offset never carries into the tag or index bits.
- Latency: with memory latency L cycles and a miss seen in cycle 0:
  - requests are issued in cycles 1..8;
  - the last word is written in cycle 8+L;
  - write_tag_array is high in cycle 9+L;
  - fsm_busy falls in cycle 10+L.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with miss_detected=1 and memory_data_valid=1 -> all outputs 0, state IDLE, no writes.
2. Basic fill, memory latency 4, miss_address=0x1234 in cycle 0:
   - mem_read=1 in cycles 1..8 with memory_address 0x1230, 0x1232, ..., 0x123E;
   - write_data_array in cycles 5..12 with matching cache_write_address and fill_data=memory_data;
   - write_tag_array=1 only in cycle 13; fsm_busy=1 in cycles 1..13 and 0 in cycle 14.
3. Stray valid: memory_data_valid=1 in IDLE and in the first FILL cycle before any return is due -> no write_data_array, and recv_cnt is unchanged.
4. Miss while busy: pulse miss_detected with address 0xABC0 during FILL -> ignored, base stays 0x1230. A miss on 0xFFFE in the cycle after TAG -> fill covers 0xFFF0..0xFFFE with no wrap into 0x0000.
5. Reset mid-fill: rst=0 after the 3rd returned word, then resume returning data -> no further writes, no write_tag_array, and fsm_busy=0 after the reset edge.
6. Irregular returns: memory_data_valid with gaps (pattern 1,0,1,1,0,...) -> exactly 8 writes in order at 0x..0 through 0x..E, then one write_tag_array.
